spike_decoder: RTL and testbench
================================

SPIKE_DECODER -- requirements
Module: spike_decoder

Interface
REQ-001 Parameter WINDOW, default 256, meaning the window length in clk cycles; legal range is 2..65535.
REQ-002 Parameter SAT, default 255, meaning the saturation value for the rate and isi outputs; it SHALL be fixed at 255 for the 8-bit outputs.
REQ-003 clk  input  1  SHALL be the single clock; all state is updated on its rising edge.
REQ-004 reset_n  input  1  SHALL be the reset: asynchronous and active-low.
REQ-005 enable  input  1  SHALL be the run control; 1 = measure, 0 = idle.
REQ-006 spike  input  1  SHALL be the spike train from the neuron (level signal).
REQ-007 out_ready  input  1  SHALL be the consumer ready signal.
REQ-008 out_valid  output  1  SHALL be the measurement-valid flag.
REQ-009 rate  output  8  SHALL be the spike-event count of the last completed window, saturated.
REQ-010 isi  output  8  SHALL be the most recent inter-spike interval in cycles, saturated.
REQ-011 overrun  output  1  SHALL be a sticky flag set when an unconsumed measurement is overwritten.

Function
REQ-012 Edge detection SHALL use a registered copy spike_q (reset 0); event = spike AND NOT spike_q; a level held high for N cycles SHALL count as one event.
REQ-013 The FSM SHALL have two states: IDLE (reset state) and RUN.
REQ-014 IDLE->RUN SHALL occur on the first cycle enable=1; on that cycle win_cnt, spk_cnt, isi_cnt and have_prev are cleared to 0, and any event on that cycle is ignored.
REQ-015 RUN->IDLE SHALL occur on any cycle enable=0; the partial window is discarded with no publish, and out_valid, rate, isi and overrun hold their values.
REQ-016 Events SHALL be ignored in IDLE; spike_q SHALL track spike in both states.
REQ-017 In RUN, win_cnt SHALL increment by 1 per cycle from 0 to WINDOW-1, then wrap to 0.
REQ-018 In RUN, an event SHALL increment spk_cnt, saturating at 255.
REQ-019 isi_cnt: on an event it SHALL load 0; otherwise it SHALL increment, saturating at 255.
REQ-020 On an event with have_prev=1, isi_last SHALL load min(isi_cnt+1, 255), so events k cycles apart give isi=k.
REQ-021 Every event SHALL set have_prev to 1; when have_prev=0 (no prior event since entering RUN), isi_last SHALL stay 0.
REQ-022 Publish SHALL occur on the RUN cycle with win_cnt=WINDOW-1.
REQ-023 On publish, rate SHALL load min(spk_cnt + event_this_cycle, 255), so an event on the final cycle counts in the closing window.
REQ-024 On publish, isi SHALL load isi_last including any update from that cycle.
REQ-025 On publish, out_valid SHALL be set to 1 and spk_cnt cleared; isi_cnt and have_prev SHALL carry across windows.
REQ-026 Latency: publish values SHALL be visible on outputs the cycle after the final window cycle.
REQ-027 Transfer SHALL occur on any cycle with out_valid=1 and out_ready=1; out_valid SHALL then drop next cycle unless a publish occurs the same cycle, in which case out_valid stays 1 with the new values.
REQ-028 While out_valid=1 and out_ready=0, rate and isi SHALL remain stable, except on publish.
REQ-029 A publish while out_valid=1 and out_ready=0 SHALL overwrite rate and isi and set overrun=1.
REQ-030 overrun SHALL be cleared only by reset.
REQ-031 out_ready SHALL have no effect when out_valid=0.
REQ-032 rate, isi, out_valid and overrun SHALL be driven directly from registers.

Reset
REQ-033 reset_n=0 SHALL immediately, independent of clk, force: state IDLE, spike_q=0, win_cnt=0, spk_cnt=0, isi_cnt=0, isi_last=0, have_prev=0, out_valid=0, rate=0, isi=0, overrun=0.
REQ-034 Reset asserted mid-window or mid-handshake SHALL abort all activity with no publish; operation resumes from IDLE after reset_n=1.

Verification
REQ-035 Reset: assert reset_n=0 mid-window with out_valid=1 -> all outputs read 0 before the next clk edge.
REQ-036 WINDOW=16, enable=1, single-cycle spikes every 4 cycles (4 events in the window) -> out_valid=1 one cycle after the 16th RUN cycle with rate=4, isi=4.
REQ-037 spike held high 10 cycles within one window -> rate=1; an event on the final window cycle -> counted in the closing window.
REQ-038 out_ready=0 across two publishes (first rate=3, second rate=5) -> overrun=1, rate=5; then out_ready=1 -> out_valid drops next cycle and overrun stays 1.
REQ-039 WINDOW=600, spike toggling every cycle -> rate=255; two events 300 cycles apart -> isi=255; first event only -> isi=0.
REQ-040 enable dropped at win_cnt=10 and re-raised -> no publish; the next publish occurs a full WINDOW cycles after re-entering RUN.

Source files
------------

// File: rtl/spike_decoder.sv
// Spike-train decoder: counts rising-edge spike events per fixed window and
// tracks the latest inter-spike interval, publishing both over a valid/ready pair.
module spike_decoder #(
   parameter int unsigned WINDOW = 256,
   parameter int unsigned SAT    = 255
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       enable,
   input  logic       spike,
   input  logic       out_ready,
   output logic       out_valid,
   output logic [7:0] rate,
   output logic [7:0] isi,
   output logic       overrun
);

   localparam int unsigned   CW    = $clog2(WINDOW);
   localparam logic [CW-1:0] LAST  = CW'(WINDOW - 1);
   localparam logic [7:0]    SAT_V = 8'(SAT);

   typedef enum logic {IDLE, RUN} state_e;

   state_e        state_q, state_d;
   logic          spike_q, spike_d;
   logic [CW-1:0] win_cnt_q, win_cnt_d;
   logic [7:0]    spk_cnt_q, spk_cnt_d;
   logic [7:0]    isi_cnt_q, isi_cnt_d;
   logic [7:0]    isi_last_q, isi_last_d;
   logic          have_prev_q, have_prev_d;
   logic          out_valid_q, out_valid_d;
   logic [7:0]    rate_q, rate_d;
   logic [7:0]    isi_q, isi_d;
   logic          overrun_q, overrun_d;

   logic          active;
   logic          spk_event;
   logic          publish;
   logic [7:0]    spk_sum;

   // NOTE: state flops use non-blocking assignments so every flop samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (enable)  state_d = RUN;
         RUN:     if (!enable) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Measurement only advances on RUN cycles that keep enable high; the
   // cycle that drops enable abandons the partial window.
   assign active    = (state_q == RUN) && enable;
   assign spk_event = active && spike && !spike_q;
   assign publish   = active && (win_cnt_q == LAST);
   assign spk_sum   = (spk_event && spk_cnt_q != SAT_V) ? spk_cnt_q + 8'd1 : spk_cnt_q;

   always_comb begin
      // NOTE: every target gets a default here, so no path can infer a latch.
      spike_d     = spike;
      win_cnt_d   = win_cnt_q;
      spk_cnt_d   = spk_cnt_q;
      isi_cnt_d   = isi_cnt_q;
      isi_last_d  = isi_last_q;
      have_prev_d = have_prev_q;
      out_valid_d = out_valid_q;
      rate_d      = rate_q;
      isi_d       = isi_q;
      overrun_d   = overrun_q;

      if (state_q == IDLE && enable) begin
         win_cnt_d   = '0;
         spk_cnt_d   = '0;
         isi_cnt_d   = '0;
         isi_last_d  = '0;
         have_prev_d = 1'b0;
      end else if (active) begin
         win_cnt_d = publish ? '0 : win_cnt_q + 1'b1;
         spk_cnt_d = publish ? 8'd0 : spk_sum;
         if (spk_event) begin
            isi_cnt_d   = '0;
            have_prev_d = 1'b1;
            if (have_prev_q)
               isi_last_d = (isi_cnt_q == SAT_V) ? SAT_V : isi_cnt_q + 8'd1;
         end else if (isi_cnt_q != SAT_V) begin
            isi_cnt_d = isi_cnt_q + 8'd1;
         end
      end

      if (publish) begin
         rate_d      = spk_sum;
         isi_d       = isi_last_d;
         out_valid_d = 1'b1;
         if (out_valid_q && !out_ready) overrun_d = 1'b1;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // NOTE: every flop here is reset asynchronously; none of them is a memory array.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         spike_q     <= 1'b0;
         win_cnt_q   <= '0;
         spk_cnt_q   <= '0;
         isi_cnt_q   <= '0;
         isi_last_q  <= '0;
         have_prev_q <= 1'b0;
         out_valid_q <= 1'b0;
         rate_q      <= '0;
         isi_q       <= '0;
         overrun_q   <= 1'b0;
      end else begin
         spike_q     <= spike_d;
         win_cnt_q   <= win_cnt_d;
         spk_cnt_q   <= spk_cnt_d;
         isi_cnt_q   <= isi_cnt_d;
         isi_last_q  <= isi_last_d;
         have_prev_q <= have_prev_d;
         out_valid_q <= out_valid_d;
         rate_q      <= rate_d;
         isi_q       <= isi_d;
         overrun_q   <= overrun_d;
      end
   end

   assign out_valid = out_valid_q;
   assign rate      = rate_q;
   assign isi       = isi_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_spike_decoder.sv
// Bench for spike_decoder: two instances (WINDOW=16 and WINDOW=600) share one
// stimulus stream and are compared every cycle against a timestamp-based model.
module tb_spike_decoder;

   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic       enable = 1'b0;
   logic       spike = 1'b0;
   logic       out_ready = 1'b0;
   logic       valid_o [2];
   logic [7:0] rate_o  [2];
   logic [7:0] isi_o   [2];
   logic       ovr_o   [2];

   int    n_checks = 0;
   int    n_fail   = 0;
   int    win_len [2] = '{16, 600};
   string sfx     [2] = '{"_w16", "_w600"};

   spike_decoder #(.WINDOW(16)) dut16 (
      .clk(clk), .reset_n(reset_n), .enable(enable), .spike(spike),
      .out_ready(out_ready), .out_valid(valid_o[0]), .rate(rate_o[0]),
      .isi(isi_o[0]), .overrun(ovr_o[0])
   );

   spike_decoder #(.WINDOW(600)) dut600 (
      .clk(clk), .reset_n(reset_n), .enable(enable), .spike(spike),
      .out_ready(out_ready), .out_valid(valid_o[1]), .rate(rate_o[1]),
      .isi(isi_o[1]), .overrun(ovr_o[1])
   );

   always #5 clk = ~clk;

   // Reference model: absolute timestamps and plain counts per instance.
   int m_now;
   bit m_prev;
   bit m_run   [2];
   int m_t     [2];
   int m_cnt   [2];
   bit m_have  [2];
   int m_last  [2];
   int m_ilast [2];
   bit m_valid [2];
   int m_rate  [2];
   int m_isi   [2];
   bit m_ovr   [2];

   function automatic int sat255(input int v);
      return (v > 255) ? 255 : v;
   endfunction

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_prev = 1'b0;
      for (int i = 0; i < 2; i++) begin
         m_run[i] = 0; m_t[i] = 0; m_cnt[i] = 0; m_have[i] = 0; m_last[i] = 0;
         m_ilast[i] = 0; m_valid[i] = 0; m_rate[i] = 0; m_isi[i] = 0; m_ovr[i] = 0;
      end
   endtask

   task automatic model_step(input bit en, input bit sp, input bit rdy);
      bit ev;
      bit pub;
      ev = sp && !m_prev;
      for (int i = 0; i < 2; i++) begin
         pub = 0;
         if (!m_run[i]) begin
            if (en) begin
               m_run[i] = 1; m_t[i] = 0; m_cnt[i] = 0; m_have[i] = 0; m_ilast[i] = 0;
            end
         end else if (!en) begin
            m_run[i] = 0;
         end else begin
            if (ev) begin
               if (m_have[i]) m_ilast[i] = sat255(m_now - m_last[i]);
               m_have[i] = 1;
               m_last[i] = m_now;
               m_cnt[i]++;
            end
            if (m_t[i] == win_len[i] - 1) begin
               pub = 1;
               m_t[i] = 0;
            end else begin
               m_t[i]++;
            end
         end
         if (pub) begin
            if (m_valid[i] && !rdy) m_ovr[i] = 1;
            m_valid[i] = 1;
            m_rate[i]  = sat255(m_cnt[i]);
            m_isi[i]   = m_ilast[i];
            m_cnt[i]   = 0;
         end else if (m_valid[i] && rdy) begin
            m_valid[i] = 0;
         end
      end
      m_prev = sp;
      m_now++;
   endtask

   task automatic compare_all();
      for (int i = 0; i < 2; i++) begin
         check({"out_valid", sfx[i]}, int'(valid_o[i]), int'(m_valid[i]));
         check({"rate", sfx[i]},      int'(rate_o[i]),  m_rate[i]);
         check({"isi", sfx[i]},       int'(isi_o[i]),   m_isi[i]);
         check({"overrun", sfx[i]},   int'(ovr_o[i]),   int'(m_ovr[i]));
      end
   endtask

   // Called at a falling edge; checks the asynchronous clear before any rising edge.
   task automatic do_reset();
      reset_n = 1'b0; enable = 1'b0; spike = 1'b0; out_ready = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         check({"rst_valid", sfx[i]},   int'(valid_o[i]), 0);
         check({"rst_rate", sfx[i]},    int'(rate_o[i]),  0);
         check({"rst_isi", sfx[i]},     int'(isi_o[i]),   0);
         check({"rst_overrun", sfx[i]}, int'(ovr_o[i]),   0);
      end
      model_reset();
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic run_cycle(input bit en, input bit sp, input bit rdy);
      enable = en; spike = sp; out_ready = rdy;
      @(posedge clk);
      model_step(en, sp, rdy);
      @(negedge clk);
      compare_all();
   endtask

   initial begin
      m_now = 0;
      model_reset();
      #3;
      do_reset();

      // Spikes every 4 cycles in a 16-cycle window.
      run_cycle(1, 0, 0);
      for (int k = 0; k < 15; k++) run_cycle(1, (k % 4) == 0, 0);
      check("pre_publish_valid", int'(valid_o[0]), 0);
      run_cycle(1, 0, 0);
      check("w16_valid", int'(valid_o[0]), 1);
      check("w16_rate4", int'(rate_o[0]), 4);
      check("w16_isi4",  int'(isi_o[0]), 4);
      for (int k = 0; k < 5; k++) run_cycle(1, 0, 0);
      check("midwin_valid_before_reset", int'(valid_o[0]), 1);
      do_reset();

      // Held level counts once; event on final window cycle still counts.
      run_cycle(1, 0, 0);
      for (int k = 0; k < 16; k++) run_cycle(1, (k >= 2 && k <= 11) || k == 15, 0);
      check("held_plus_last_rate", int'(rate_o[0]), 2);
      check("held_plus_last_isi",  int'(isi_o[0]), 13);
      do_reset();

      // Two publishes without consumption, then drain.
      run_cycle(1, 0, 0);
      for (int k = 0; k < 16; k++) run_cycle(1, k == 1 || k == 5 || k == 9, 0);
      check("first_rate3",   int'(rate_o[0]), 3);
      check("first_no_ovr",  int'(ovr_o[0]), 0);
      for (int k = 0; k < 16; k++) run_cycle(1, k < 10 && (k % 2) == 0, 0);
      check("second_rate5",  int'(rate_o[0]), 5);
      check("overrun_set",   int'(ovr_o[0]), 1);
      run_cycle(1, 0, 1);
      check("drain_valid",   int'(valid_o[0]), 0);
      check("overrun_stick", int'(ovr_o[0]), 1);
      do_reset();

      // Saturation in a 600-cycle window.
      run_cycle(1, 0, 1);
      for (int k = 0; k < 600; k++) run_cycle(1, (k % 2) == 0, 1);
      check("w600_rate_sat", int'(rate_o[1]), 255);
      check("w600_isi2",     int'(isi_o[1]), 2);
      for (int k = 0; k < 600; k++) run_cycle(1, k == 0 || k == 300, 1);
      check("w600_isi_sat",  int'(isi_o[1]), 255);
      check("w600_rate2",    int'(rate_o[1]), 2);
      do_reset();
      run_cycle(1, 0, 1);
      for (int k = 0; k < 600; k++) run_cycle(1, k == 5, 0);
      check("single_event_isi0",  int'(isi_o[1]), 0);
      check("single_event_rate1", int'(rate_o[1]), 1);
      do_reset();

      // Enable dropped at win_cnt=10: partial window discarded.
      run_cycle(1, 0, 0);
      for (int k = 0; k < 10; k++) run_cycle(1, k == 3, 0);
      for (int k = 0; k < 3; k++) run_cycle(0, 0, 0);
      check("no_publish_after_drop", int'(valid_o[0]), 0);
      run_cycle(1, 0, 0);
      for (int k = 0; k < 15; k++) run_cycle(1, k == 7, 0);
      check("reentry_not_yet", int'(valid_o[0]), 0);
      run_cycle(1, 0, 0);
      check("reentry_publish", int'(valid_o[0]), 1);
      check("reentry_rate1",   int'(rate_o[0]), 1);

      // Randomized traffic with occasional resets.
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(999) == 0) do_reset();
         run_cycle($urandom_range(15) != 0, $urandom_range(2) == 0, $urandom_range(3) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
